decode_stage: RTL
=================

Name: decode_stage

Overview:
- Registered RV32I instruction-decode pipeline stage, sitting between the fetch buffer and the execute stage.
- Supersedes the purely combinational decoder with the following additions:
  - full RV32I opcode coverage, including LUI, AUIPC and load/store size;
  - illegal-instruction detection;
  - immediate generation;
  - valid/ready handshakes on both sides, with flush;
  - single-bubble load-use interlock;
  - illegal-instruction counter.

Parameters:
- XLEN, 32, datapath width; the immediate is sign-extended to XLEN.
- HAZARD_EN, 1, enables the load-use interlock. When 0, the interlock never stalls.
- CNT_W, 16, width of the illegal-instruction counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  squashes the output register and drops the input this cycle (taken branch or jump).
- in_valid  in  1  fetch has an instruction.
- in_ready  out  1  stage accepts the instruction.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  PC of in_instr.
- out_valid  out  1  decoded bundle is valid.
- out_ready  in  1  execute accepts the bundle.
- out_pc  out  XLEN  registered PC.
- out_rs1, out_rs2, out_rd  out  5 each  register indices.
- out_imm  out  XLEN  sign-extended immediate.
- out_alu_ctrl  out  4  ALU operation code.
- out_alu_src_pc  out  1  ALU operand A is the PC (AUIPC, JAL).
- out_alu_src_imm  out  1  ALU operand B is the immediate.
- out_result_src  out  2  writeback source: 00 ALU, 01 memory, 10 PC+4, 11 immediate (LUI).
- out_reg_write  out  1  writeback enable.
- out_mem_write  out  1  store enable.
- out_mem_read  out  1  load.
- out_mem_funct3  out  3  load/store size and sign.
- out_is_branch, out_is_jal, out_is_jalr  out  1 each  control-flow class.
- out_illegal  out  1  instruction is illegal.
- illegal_cnt  out  CNT_W  count of accepted illegal instructions; saturates at its maximum value.

Behaviour:
- Reset (asynchronous, rst_n low):
  - out_valid = 0;
  - every out_* bundle field = 0;
  - illegal_cnt = 0.
  - Reset mid-transfer discards the held instruction.
- Handshake:
  - in_ready = (!out_valid || out_ready) && !stall.
  - An input transfer occurs when in_valid && in_ready && !flush.
  - On a transfer, the decoded bundle is registered and out_valid = 1 next cycle. Latency is 1 cycle.
  - If out_valid && out_ready and there is no input transfer, out_valid goes to 0.
  - While out_valid && !out_ready, every out_* field is held stable.
- Flush:
  - out_valid goes to 0 next cycle.
  - The input is not accepted.
  - illegal_cnt is not incremented for that cycle.
  - Flush has priority over all other events.
- Load-use interlock (HAZARD_EN = 1):
  - stall = out_valid && out_mem_read && out_rd != 0 && ((uses_rs1 && rs1 == out_rd) || (uses_rs2 && rs2 == out_rd)).
  - rs1 and rs2 are taken from in_instr.
  - uses_rs1 covers R, I-ALU, load, store, branch and JALR. uses_rs2 covers R, store and branch.
  - When the load drains, out_valid drops, creating exactly one bubble cycle. The dependent instruction is accepted the following cycle.
- Decode, ALU codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLTU, 9 SLT.
  - SUB only for R-type with funct7 = 0100000. ADDI always decodes to ADD, regardless of bit 30.
  - SRAI/SRA are selected by instr[30] when funct3 = 101.
- Decode, branch codes on out_alu_ctrl: BEQ 0, BNE 1, BLT 2, BGE 3, BLTU 4, BGEU 5.
- Decode, load/store/JALR: ALU = ADD, imm source.
- Decode, LUI: result_src = 11, reg_write = 1.
- Decode, AUIPC: alu_src_pc = 1, ADD.
- Decode, JAL/JALR: result_src = 10, reg_write = 1.
- Immediates: I, S, B, U and J formats, each sign-extended from instr[31].
- Illegal when any of:
  - the opcode is outside the RV32I set;
  - R-type funct7 is not 0000000, or 0100000 with funct3 000 or 101;
  - shift-immediate funct7 is invalid;
  - branch funct3 is 010 or 011;
  - load funct3 is not in {000, 001, 010, 100, 101};
  - store funct3 > 010;
  - JALR funct3 != 000.
- Illegal instructions are treated as follows:
  - reg_write = 0, mem_write = 0, mem_read = 0, out_illegal = 1;
  - they still pass through the stage;
  - illegal_cnt increments once per accepted illegal instruction and saturates.
- rd = 0 with reg_write set is legal. Suppressing the write is left to the register file.

Decomposition:
- decode_pkg holds:
  - opcode constants;
  - ALU code constants;
  - result_src encodings;
  - the imm_type enum (I, S, B, U, J);
  - the decoded-bundle struct.
- imm_gen is the single natural sub-module: combinational, instr plus imm_type → XLEN-bit immediate.

Test Plan:
- add x3,x1,x2 (0x002081B3) → 1 cycle later: out_valid = 1, alu_ctrl = 0, rd = 3, rs1 = 1, rs2 = 2, reg_write = 1, result_src = 00.
- addi x1,x0,-1 (0xFFF00093) → imm = 0xFFFFFFFF, alu_ctrl = 0 (not SUB), alu_src_imm = 1.
- lw x5,0(x1) (0x0000A283), then add x6,x5,x0 (0x00028333), with out_ready = 1 → mem_read = 1 and funct3 = 010 for the lw; in_ready = 0 for one cycle; one out_valid = 0 bubble; the add appears in the cycle after the bubble. Repeat with HAZARD_EN = 0 → no bubble.
- 0x00000000, then a valid add → out_illegal = 1, reg_write = 0, illegal_cnt 0 → 1; the add decodes normally.
- Hold out_ready = 0 for 3 cycles with in_valid = 1 → in_ready = 0 and outputs stable; release → instructions emerge in order with none lost.
- Assert flush while out_valid = 1 and in_valid = 1 → next cycle out_valid = 0 and the input is not consumed. Assert rst_n low mid-stream → all outputs 0 immediately.

Source files
------------

// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared opcodes, ALU codes and decoded-bundle types for decode_stage
package decode_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLTU = 4'd8;
    localparam logic [3:0] ALU_SLT  = 4'd9;

    // Branch comparisons reuse the alu_ctrl field with their own numbering
    localparam logic [3:0] BR_BEQ  = 4'd0;
    localparam logic [3:0] BR_BNE  = 4'd1;
    localparam logic [3:0] BR_BLT  = 4'd2;
    localparam logic [3:0] BR_BGE  = 4'd3;
    localparam logic [3:0] BR_BLTU = 4'd4;
    localparam logic [3:0] BR_BGEU = 4'd5;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;
    localparam logic [1:0] RES_IMM = 2'b11;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_type_e;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [3:0] alu_ctrl;
        logic       alu_src_pc;
        logic       alu_src_imm;
        logic [1:0] result_src;
        logic       reg_write;
        logic       mem_write;
        logic       mem_read;
        logic [2:0] mem_funct3;
        logic       is_branch;
        logic       is_jal;
        logic       is_jalr;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - RV32I immediate extraction, sign-extended to XLEN
module imm_gen
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     instr_i,
    input  imm_type_e       imm_type_i,
    output logic [XLEN-1:0] imm_o
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (imm_type_i)
            IMM_I:   imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_S:   imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B:   imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                              instr_i[11:8], 1'b0};
            IMM_U:   imm32 = {instr_i[31:12], 12'b0};
            IMM_J:   imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                              instr_i[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm_o = {{(XLEN-31){imm32[31]}}, imm32[30:0]};

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered RV32I decode stage with handshakes, flush and load-use interlock
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit HAZARD_EN = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output logic [XLEN-1:0]  out_imm,
    output logic [3:0]       out_alu_ctrl,
    output logic             out_alu_src_pc,
    output logic             out_alu_src_imm,
    output logic [1:0]       out_result_src,
    output logic             out_reg_write,
    output logic             out_mem_write,
    output logic             out_mem_read,
    output logic [2:0]       out_mem_funct3,
    output logic             out_is_branch,
    output logic             out_is_jal,
    output logic             out_is_jalr,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    ctrl_t           ctrl_d, ctrl_q;
    logic [XLEN-1:0] pc_q, imm_d, imm_q, imm_raw;
    logic            valid_d, valid_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    imm_type_e       imm_type;
    logic            has_imm, uses_rs1, uses_rs2;
    logic            hazard, stall, xfer;
    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr_i    (in_instr[31:7]),
        .imm_type_i (imm_type),
        .imm_o      (imm_raw)
    );

    always_comb begin
        ctrl_d     = '0;
        imm_type   = IMM_I;
        has_imm    = 1'b0;
        uses_rs1   = 1'b0;
        uses_rs2   = 1'b0;
        ctrl_d.rs1 = in_instr[19:15];
        ctrl_d.rs2 = in_instr[24:20];
        ctrl_d.rd  = in_instr[11:7];
        case (opcode)
            OP_REG: begin
                ctrl_d.reg_write = 1'b1;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                case (funct3)
                    3'b000:  ctrl_d.alu_ctrl = funct7[5] ? ALU_SUB : ALU_ADD;
                    3'b001:  ctrl_d.alu_ctrl = ALU_SLL;
                    3'b010:  ctrl_d.alu_ctrl = ALU_SLT;
                    3'b011:  ctrl_d.alu_ctrl = ALU_SLTU;
                    3'b100:  ctrl_d.alu_ctrl = ALU_XOR;
                    3'b101:  ctrl_d.alu_ctrl = funct7[5] ? ALU_SRA : ALU_SRL;
                    3'b110:  ctrl_d.alu_ctrl = ALU_OR;
                    default: ctrl_d.alu_ctrl = ALU_AND;
                endcase
                ctrl_d.illegal = !((funct7 == F7_ZERO) ||
                                   (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)));
            end
            OP_IMM: begin
                ctrl_d.reg_write   = 1'b1;
                ctrl_d.alu_src_imm = 1'b1;
                has_imm  = 1'b1;
                uses_rs1 = 1'b1;
                case (funct3)
                    3'b000:  ctrl_d.alu_ctrl = ALU_ADD;
                    3'b001: begin
                        ctrl_d.alu_ctrl = ALU_SLL;
                        ctrl_d.illegal  = (funct7 != F7_ZERO);
                    end
                    3'b010:  ctrl_d.alu_ctrl = ALU_SLT;
                    3'b011:  ctrl_d.alu_ctrl = ALU_SLTU;
                    3'b100:  ctrl_d.alu_ctrl = ALU_XOR;
                    3'b101: begin
                        ctrl_d.alu_ctrl = in_instr[30] ? ALU_SRA : ALU_SRL;
                        ctrl_d.illegal  = (funct7 != F7_ZERO) && (funct7 != F7_ALT);
                    end
                    3'b110:  ctrl_d.alu_ctrl = ALU_OR;
                    default: ctrl_d.alu_ctrl = ALU_AND;
                endcase
            end
            OP_LOAD: begin
                ctrl_d.reg_write   = 1'b1;
                ctrl_d.mem_read    = 1'b1;
                ctrl_d.result_src  = RES_MEM;
                ctrl_d.alu_src_imm = 1'b1;
                ctrl_d.mem_funct3  = funct3;
                has_imm  = 1'b1;
                uses_rs1 = 1'b1;
                ctrl_d.illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OP_STORE: begin
                ctrl_d.mem_write   = 1'b1;
                ctrl_d.alu_src_imm = 1'b1;
                ctrl_d.mem_funct3  = funct3;
                imm_type = IMM_S;
                has_imm  = 1'b1;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                ctrl_d.illegal = (funct3 > 3'b010);
            end
            OP_BRANCH: begin
                ctrl_d.is_branch = 1'b1;
                imm_type = IMM_B;
                has_imm  = 1'b1;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                case (funct3)
                    3'b000:  ctrl_d.alu_ctrl = BR_BEQ;
                    3'b001:  ctrl_d.alu_ctrl = BR_BNE;
                    3'b100:  ctrl_d.alu_ctrl = BR_BLT;
                    3'b101:  ctrl_d.alu_ctrl = BR_BGE;
                    3'b110:  ctrl_d.alu_ctrl = BR_BLTU;
                    3'b111:  ctrl_d.alu_ctrl = BR_BGEU;
                    default: ctrl_d.illegal  = 1'b1;
                endcase
            end
            OP_LUI: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.result_src = RES_IMM;
                imm_type = IMM_U;
                has_imm  = 1'b1;
            end
            OP_AUIPC: begin
                ctrl_d.reg_write   = 1'b1;
                ctrl_d.alu_src_pc  = 1'b1;
                ctrl_d.alu_src_imm = 1'b1;
                imm_type = IMM_U;
                has_imm  = 1'b1;
            end
            OP_JAL: begin
                ctrl_d.reg_write   = 1'b1;
                ctrl_d.is_jal      = 1'b1;
                ctrl_d.result_src  = RES_PC4;
                ctrl_d.alu_src_pc  = 1'b1;
                ctrl_d.alu_src_imm = 1'b1;
                imm_type = IMM_J;
                has_imm  = 1'b1;
            end
            OP_JALR: begin
                ctrl_d.reg_write   = 1'b1;
                ctrl_d.is_jalr     = 1'b1;
                ctrl_d.result_src  = RES_PC4;
                ctrl_d.alu_src_imm = 1'b1;
                has_imm  = 1'b1;
                uses_rs1 = 1'b1;
                ctrl_d.illegal = (funct3 != 3'b000);
            end
            default: ctrl_d.illegal = 1'b1;
        endcase
        // Illegal words still flow downstream but must not touch architectural state
        if (ctrl_d.illegal) begin
            ctrl_d.reg_write = 1'b0;
            ctrl_d.mem_write = 1'b0;
            ctrl_d.mem_read  = 1'b0;
        end
    end

    assign imm_d = has_imm ? imm_raw : '0;

    assign hazard = valid_q && ctrl_q.mem_read && (ctrl_q.rd != 5'd0) &&
                    ((uses_rs1 && (ctrl_d.rs1 == ctrl_q.rd)) ||
                     (uses_rs2 && (ctrl_d.rs2 == ctrl_q.rd)));
    assign stall    = HAZARD_EN && hazard;
    assign in_ready = (!valid_q || out_ready) && !stall;
    assign xfer     = in_valid && in_ready && !flush;

    always_comb begin
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (xfer) begin
            valid_d = 1'b1;
            if (ctrl_d.illegal && (cnt_q != '1)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            cnt_q   <= '0;
            ctrl_q  <= '0;
            pc_q    <= '0;
            imm_q   <= '0;
        end else begin
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            if (xfer) begin
                ctrl_q <= ctrl_d;
                pc_q   <= in_pc;
                imm_q  <= imm_d;
            end
        end
    end

    assign out_valid       = valid_q;
    assign out_pc          = pc_q;
    assign out_imm         = imm_q;
    assign out_rs1         = ctrl_q.rs1;
    assign out_rs2         = ctrl_q.rs2;
    assign out_rd          = ctrl_q.rd;
    assign out_alu_ctrl    = ctrl_q.alu_ctrl;
    assign out_alu_src_pc  = ctrl_q.alu_src_pc;
    assign out_alu_src_imm = ctrl_q.alu_src_imm;
    assign out_result_src  = ctrl_q.result_src;
    assign out_reg_write   = ctrl_q.reg_write;
    assign out_mem_write   = ctrl_q.mem_write;
    assign out_mem_read    = ctrl_q.mem_read;
    assign out_mem_funct3  = ctrl_q.mem_funct3;
    assign out_is_branch   = ctrl_q.is_branch;
    assign out_is_jal      = ctrl_q.is_jal;
    assign out_is_jalr     = ctrl_q.is_jalr;
    assign out_illegal     = ctrl_q.illegal;
    assign illegal_cnt     = cnt_q;

endmodule
